// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the forwarding/hazard unit.
package fwd_pkg;
    localparam int MAX_ADDR_W = 8;
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_t;
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  is_load;
        logic [MAX_ADDR_W-1:0] rd;
    } pipe_rec_t;
    function automatic logic rec_writes(pipe_rec_t r, logic [MAX_ADDR_W-1:0] a);
        return r.valid && r.we && r.rd != '0 && r.rd == a;
    endfunction
endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: one source address against the EX/MEM shadow records.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  pipe_rec_t             ex_rec,
    input  pipe_rec_t             mem_rec,
    output fwd_sel_t              sel,
    output logic                  load_use
);
    logic [MAX_ADDR_W-1:0] a;
    always_comb begin
        a        = MAX_ADDR_W'(rs);
        sel      = !used ? FWD_RF : rec_writes(ex_rec, a) ? FWD_EXMEM :
                   rec_writes(mem_rec, a) ? FWD_MEMWB : FWD_RF;
        load_use = used && ex_rec.is_load && rec_writes(ex_rec, a);
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: registered forwarding selects and counted load-use stall.
// Define FWD_STATS_EN to add the stall_cnt/fwd_cnt statistics outputs.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_we,
    input  logic                          id_is_load,
    input  logic                          redirect,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
`ifdef FWD_STATS_EN
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_cnt,
    output logic                          stall
`else
    output logic                          stall
`endif
);
    localparam int CNT_W = 2;
    // WB needs no shadow: nothing forwards from it, the register file write covers it
    pipe_rec_t            ex_rec, mem_rec, id_rec;
    fwd_sel_t             sel [NUM_SRC];
    logic [NUM_SRC-1:0]   lu;
    logic [2*NUM_SRC-1:0] sel_flat;
    logic [CNT_W-1:0]     stall_left;
    logic                 hazard, advance;
    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
                .rs       (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
                .used     (id_rs_used[i]),
                .ex_rec   (ex_rec),
                .mem_rec  (mem_rec),
                .sel      (sel[i]),
                .load_use (lu[i])
            );
            assign sel_flat[2*i +: 2] = sel[i];
        end
    endgenerate
    assign id_rec  = '{valid: 1'b1, we: id_we, is_load: id_is_load, rd: MAX_ADDR_W'(id_rd)};
    assign hazard  = id_valid && |lu;
    assign stall   = !redirect && (stall_left != '0 || hazard);
    assign advance = id_valid && !stall && !redirect;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rec     <= '0;
            mem_rec    <= '0;
            fwd_sel    <= '0;
            stall_left <= '0;
        end else begin
            mem_rec    <= ex_rec;
            ex_rec     <= advance ? id_rec : '0;
            fwd_sel    <= advance ? sel_flat : '0;
            stall_left <= redirect ? '0 : stall_left != '0 ? stall_left - 1'b1 :
                          hazard ? CNT_W'(LOAD_LAT - 1) : '0;
        end
    end
`ifdef FWD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(stall);
            fwd_cnt   <= fwd_cnt + 32'(|fwd_sel);
        end
    end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors on three instances (LOAD_LAT 1, 2, 3).
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       redirect = 1'b0;
    logic       id_we = 1'b0;
    logic       id_is_load = 1'b0;
    logic [2:0] vld = '0;
    logic [9:0] id_rs = '0;
    logic [1:0] used = '0;
    logic [4:0] id_rd = '0;
    logic [3:0] fs [3];
    logic       st [3];
`ifdef FWD_STATS_EN
    logic [31:0] sc [3];
    logic [31:0] fc [3];
`endif
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .id_valid   (vld[g]),
            .id_rs      (id_rs),
            .id_rs_used (used),
            .id_rd      (id_rd),
            .id_we      (id_we),
            .id_is_load (id_is_load),
            .redirect   (redirect),
            .fwd_sel    (fs[g]),
`ifdef FWD_STATS_EN
            .stall_cnt  (sc[g]),
            .fwd_cnt    (fc[g]),
`endif
            .stall      (st[g])
        );
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic inst(input int k, input int rd, input int rs1, input int rs2,
                        input int u, input int we, input int ld);
        @(negedge clk);
        redirect   = 1'b0;
        vld        = 3'(1 << k);
        id_rd      = 5'(rd);
        id_rs      = {5'(rs2), 5'(rs1)};
        used       = 2'(u);
        id_we      = we != 0;
        id_is_load = ld != 0;
        #1;
    endtask
    task automatic idle();
        @(negedge clk);
        redirect = 1'b0;
        vld      = '0;
        #1;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_fs", 32'(fs[k]), 0);
            check("rst_st", 32'(st[k]), 0);
        end
        rst = 1'b0;
        idle();
        // back-to-back ALU dependency: EX/MEM forward on source 0
        inst(0, 5, 1, 2, 3, 1, 0);
        check("alu_st", 32'(st[0]), 0);
        inst(0, 6, 5, 7, 3, 1, 0);
        check("dep_st", 32'(st[0]), 0);
        idle();
        check("exmem_fs", 32'(fs[0]), 'b0010);
        idle();
        check("bubble_fs", 32'(fs[0]), 0);
        // one independent op in between: MEM/WB forward; x0 on source 1 stays 00
        inst(0, 8, 1, 2, 3, 1, 0);
        inst(0, 9, 3, 4, 3, 1, 0);
        inst(0, 10, 8, 0, 3, 1, 0);
        idle();
        check("memwb_fs", 32'(fs[0]), 'b0001);
        // two writers of x8 in flight: youngest wins on both sources
        inst(0, 8, 1, 2, 3, 1, 0);
        inst(0, 8, 3, 4, 3, 1, 0);
        inst(0, 11, 8, 8, 3, 1, 0);
        idle();
        check("young_fs", 32'(fs[0]), 'b1010);
        // load to x0 then read x0: no hazard, no forward
        repeat (2) idle();
        inst(0, 0, 1, 2, 3, 1, 1);
        inst(0, 12, 0, 0, 3, 1, 0);
        check("x0_st", 32'(st[0]), 0);
        idle();
        check("x0_fs", 32'(fs[0]), 0);
        // unused sources never forward
        inst(0, 13, 1, 2, 3, 1, 0);
        inst(0, 14, 13, 13, 0, 1, 0);
        idle();
        check("unused_fs", 32'(fs[0]), 0);
        // load-use, LOAD_LAT=1
        repeat (2) idle();
        inst(0, 5, 1, 0, 1, 1, 1);
        inst(0, 6, 5, 5, 3, 1, 0);
        check("lu1_st", 32'(st[0]), 1);
        inst(0, 6, 5, 5, 3, 1, 0);
        check("lu1_st_end", 32'(st[0]), 0);
        check("lu1_bub_fs", 32'(fs[0]), 0);
        idle();
        check("lu1_fs", 32'(fs[0]), 'b0101);
        // load-use, LOAD_LAT=3
        repeat (2) idle();
        inst(2, 5, 1, 0, 1, 1, 1);
        for (int j = 0; j < 3; j++) begin
            inst(2, 6, 5, 5, 3, 1, 0);
            check("lu3_st", 32'(st[2]), 1);
        end
        inst(2, 6, 5, 5, 3, 1, 0);
        check("lu3_st_end", 32'(st[2]), 0);
        idle();
        check("lu3_fs", 32'(fs[2]), 0);
        // redirect in the first stall cycle, LOAD_LAT=2
        repeat (2) idle();
        inst(1, 5, 1, 0, 1, 1, 1);
        inst(1, 6, 5, 5, 3, 1, 0);
        check("rd_pre_st", 32'(st[1]), 1);
        redirect = 1'b1;
        #1;
        check("rd_same_st", 32'(st[1]), 0);
        inst(1, 7, 5, 0, 1, 1, 0);
        check("rd_next_st", 32'(st[1]), 0);
        check("rd_next_fs", 32'(fs[1]), 0);
        idle();
        check("rd_issue_fs", 32'(fs[1]), 'b0001);
        // asynchronous reset in the middle of a stall
        repeat (2) idle();
        inst(1, 5, 1, 0, 1, 1, 1);
        inst(1, 6, 5, 5, 3, 1, 0);
        check("arst_pre_st", 32'(st[1]), 1);
        rst = 1'b1;
        vld = '0;
        #1;
        check("arst_st", 32'(st[1]), 0);
        check("arst_fs", 32'(fs[1]), 0);
        @(negedge clk);
        rst = 1'b0;
`ifdef FWD_STATS_EN
        check("stat_rst_sc", sc[1], 0);
        for (int r = 0; r < 2; r++) begin
            inst(1, 5, 1, 0, 1, 1, 1);
            repeat (3) inst(1, 6, 5, 5, 3, 1, 0);
            idle();
        end
        inst(1, 5, 1, 2, 3, 1, 0);
        inst(1, 6, 5, 7, 3, 1, 0);
        repeat (2) idle();
        check("stat_sc", sc[1], 4);
        check("stat_fc", fc[1], 1);
        rst = 1'b1;
        #1;
        check("stat_arst_sc", sc[1], 0);
        check("stat_arst_fc", fc[1], 0);
        @(negedge clk);
        rst = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
